// File: rtl/idct_pkg.sv
`default_nettype none
// idct_pkg -- shared constants, scheduler state type and the round/saturate helper.
// Rev 1.0
package idct_pkg;

  localparam int DW     = 16;
  localparam int IW     = 25;
  localparam int SHIFT1 = 7;
  localparam int SHIFT2 = 12;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_COL  = 2'd1,
    ST_ROW  = 2'd2
  } state_e;

  localparam logic signed [IW-1:0] SAT_HI = IW'((1 << (DW - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_LO = -SAT_HI - IW'(1);

  // Round half up, floor via arithmetic shift, then clip to the DW-bit range.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [IW-1:0] sum,
                                                     input logic [4:0]           sh);
    logic signed [IW-1:0] rnd;
    logic signed [IW-1:0] r;
    rnd = {{(IW-1){1'b0}}, 1'b1} << (sh - 5'd1);
    r   = (sum + rnd) >>> sh;
    if (r > SAT_HI)      round_sat = SAT_HI[DW-1:0];
    else if (r < SAT_LO) round_sat = SAT_LO[DW-1:0];
    else                 round_sat = r[DW-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/idct4_core.sv
`default_nettype none
// idct4_core -- combinational 4-point inverse DCT butterfly with selectable rounding shift.
// Rev 1.0
module idct4_core
  import idct_pkg::*;
#(
  parameter int COL_SHIFT = idct_pkg::SHIFT1,
  parameter int ROW_SHIFT = idct_pkg::SHIFT2
) (
  input  logic [4*DW-1:0] a_i,
  input  logic            row_pass_i,
  output logic [4*DW-1:0] y_o
);

  localparam logic signed [IW-1:0] K64 = IW'(C64);
  localparam logic signed [IW-1:0] K83 = IW'(C83);
  localparam logic signed [IW-1:0] K36 = IW'(C36);

  logic signed [IW-1:0] a [4];
  logic signed [IW-1:0] s [4];
  logic [4:0]           sh;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k] = IW'(signed'(a_i[k*DW +: DW]));
    end
    s[0] = K64*a[0] + K83*a[1] + K64*a[2] + K36*a[3];
    s[1] = K64*a[0] + K36*a[1] - K64*a[2] - K83*a[3];
    s[2] = K64*a[0] - K36*a[1] - K64*a[2] + K83*a[3];
    s[3] = K64*a[0] - K83*a[1] + K64*a[2] - K36*a[3];
    sh   = row_pass_i ? 5'(ROW_SHIFT) : 5'(COL_SHIFT);
    for (int k = 0; k < 4; k++) begin
      y_o[k*DW +: DW] = round_sat(s[k], sh);
    end
  end

endmodule
`default_nettype wire

// File: rtl/idct4x4_sched.sv
`default_nettype none
// idct4x4_sched -- loads a 4x4 coefficient block, runs the column pass in place, streams the row pass.
// Rev 1.0
module idct4x4_sched #(
  parameter int SHIFT1 = idct_pkg::SHIFT1,
  parameter int SHIFT2 = idct_pkg::SHIFT2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [4*idct_pkg::DW-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [4*idct_pkg::DW-1:0] m_data,
  output logic                      m_last
);
  import idct_pkg::*;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   coef_q [4][4];
  logic            m_valid_q;
  logic            m_last_q;
  logic [4*DW-1:0] m_data_q;

  logic            accept;
  logic            col_step;
  logic            issue;
  logic [4*DW-1:0] core_a;
  logic [4*DW-1:0] core_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_LOAD: if (accept) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_COL;
      end
      ST_COL: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_ROW;
      end
      ST_ROW: if (issue) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // A new row may be issued whenever the output register is empty or being drained.
  always_comb begin
    s_ready  = (state_q == ST_LOAD);
    accept   = s_ready && s_valid;
    col_step = (state_q == ST_COL);
    issue    = (state_q == ST_ROW) && (!m_valid_q || m_ready);
  end

  always_comb begin
    core_a = '0;
    for (int k = 0; k < 4; k++) begin
      if (col_step) core_a[k*DW +: DW] = coef_q[k][idx_q];
      else          core_a[k*DW +: DW] = coef_q[idx_q][k];
    end
  end

  idct4_core #(
    .COL_SHIFT (SHIFT1),
    .ROW_SHIFT (SHIFT2)
  ) u_core (
    .a_i        (core_a),
    .row_pass_i (state_q == ST_ROW),
    .y_o        (core_y)
  );

  // Column results overwrite the column they were read from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          coef_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < 4; c++) begin
        coef_q[idx_q][c] <= s_data[c*DW +: DW];
      end
    end else if (col_step) begin
      for (int r = 0; r < 4; r++) begin
        coef_q[r][idx_q] <= core_y[r*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (issue) begin
      m_valid_q <= 1'b1;
      m_last_q  <= (idx_q == 2'd3);
      m_data_q  <= core_y;
    end else if (m_valid_q && m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_idct4x4_sched.sv
`default_nettype none
`timescale 1ns/1ps
// tb_idct4x4_sched -- table-driven and randomized checks of idct4x4_sched against a matrix-form model.
module tb_idct4x4_sched;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [4*DW-1:0] s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [4*DW-1:0] m_data;
  logic            m_last;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int rx_cnt = 0;
  bit rnd_bp = 0;
  int M [4][4];
  logic [4*DW-1:0] rx_rows [4];

  typedef struct packed {
    logic [4*DW-1:0] data;
    logic            last;
  } row_t;
  row_t exp_q [$];

  typedef struct packed {
    logic [16*DW-1:0]       coef;
    logic signed [DW-1:0]   exp00;
  } vec_t;
  vec_t tbl [4];

  idct4x4_sched dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (rnd_bp) m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat_shift(input int s, input int sh);
    int r;
    r = (s + (1 << (sh - 1))) >>> sh;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  // Two matrix passes: columns with shift 7, then rows with shift 12.
  task automatic idct_ref(input int c [16], output int o [16]);
    int t [16];
    int acc;
    for (int col = 0; col < 4; col++)
      for (int k = 0; k < 4; k++) begin
        acc = 0;
        for (int n = 0; n < 4; n++) acc += M[k][n] * c[n*4 + col];
        t[k*4 + col] = sat_shift(acc, 7);
      end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        acc = 0;
        for (int n = 0; n < 4; n++) acc += M[k][n] * t[r*4 + n];
        o[r*4 + k] = sat_shift(acc, 12);
      end
  endtask

  task automatic expect_block(input int c [16]);
    int   o [16];
    row_t e;
    idct_ref(c, o);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) e.data[k*DW +: DW] = 16'(o[r*4 + k]);
      e.last = (r == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_block(output int c [16]);
    int mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0:       c[k] = int'($urandom_range(0, 65535)) - 32768;
        1:       c[k] = int'($urandom_range(0, 1024)) - 512;
        default: c[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768 : 0;
      endcase
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with t_acc = edge of the last accepted beat.
  task automatic send_block(input int c [16], output int t_acc);
    int g;
    for (int r = 0; r < 4; r++) begin
      s_valid = 1'b1;
      for (int k = 0; k < 4; k++) s_data[k*DW +: DW] = 16'(c[r*4 + k]);
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!s_ready && g < 200);
      if (!s_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL s_ready_timeout: got s_ready=0 for 200 cycles, required 1");
      end
      @(posedge clk);
      #1;
    end
    t_acc = cyc;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending_rows", 80'(exp_q.size()), 80'(0));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    row_t e;
    if (reset && m_valid && m_ready) begin
      rx_rows[rx_cnt % 4] = m_data;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_row: got %h, required no row", m_data);
      end else begin
        e = exp_q.pop_front();
        check("row_data_last", 80'({m_last, m_data}), 80'({e.last, e.data}));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c [16];
    int t, tv, ts;
    int tb2b [6];
    logic [4*DW-1:0] d0;
    logic            l0;

    M = '{'{64, 83, 64, 36}, '{64, 36, -64, -83}, '{64, -36, -64, 83}, '{64, -83, 64, -36}};

    tbl[0].coef = '0;                 tbl[0].exp00 = 16'sd0;
    tbl[1].coef = '0;                 tbl[1].exp00 = 16'sd1;
    tbl[1].coef[DW-1:0] = 16'd64;
    tbl[2].coef = {16{16'h7FFF}};     tbl[2].exp00 = 16'sd1976;
    tbl[3].coef = {16{16'h8000}};     tbl[3].exp00 = -16'sd1976;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 80'({m_valid, m_last, s_ready, m_data}), 80'({1'b0, 1'b0, 1'b1, 64'h0}));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_reset", 80'(s_ready), 80'(1));

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) c[k] = int'(signed'(tbl[i].coef[k*DW +: DW]));
      expect_block(c);
      rx_cnt = 0;
      send_block(c, t);
      s_valid = 1'b0;
      tv = -1;
      ts = -1;
      for (int k = 0; k < 30 && (tv < 0 || ts < 0); k++) begin
        @(negedge clk);
        if (tv < 0 && m_valid) tv = cyc - t;
        if (ts < 0 && s_ready) ts = cyc - t;
      end
      check("first_m_valid_latency", 80'(tv), 80'(5));
      check("s_ready_return_latency", 80'(ts), 80'(8));
      drain();
      check("rows_per_block", 80'(rx_cnt), 80'(4));
      check("row0_lane0", 80'(int'(signed'(rx_rows[0][DW-1:0]))), 80'(int'(tbl[i].exp00)));
    end

    // Back-pressure on row 1.
    rand_block(c);
    expect_block(c);
    rx_cnt = 0;
    send_block(c, t);
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    d0 = m_data;
    l0 = m_last;
    check("bp_row1_valid", 80'({m_valid, m_last}), 80'({1'b1, 1'b0}));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", 80'({m_valid, s_ready, m_last, m_data}), 80'({1'b1, 1'b0, l0, d0}));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain();
    check("bp_rows_per_block", 80'(rx_cnt), 80'(4));

    // Back-to-back blocks with s_valid held high.
    for (int b = 0; b < 6; b++) begin
      rand_block(c);
      expect_block(c);
      send_block(c, tb2b[b]);
      if (b > 0) check("b2b_block_period", 80'(tb2b[b] - tb2b[b-1]), 80'(12));
    end
    s_valid = 1'b0;
    drain();

    // Random back-pressure.
    rnd_bp = 1;
    for (int b = 0; b < 5; b++) begin
      rand_block(c);
      expect_block(c);
      send_block(c, t);
    end
    s_valid = 1'b0;
    drain();
    rnd_bp = 0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;

    // Reset in the middle of the column pass; the aborted block produces nothing.
    rand_block(c);
    send_block(c, t);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("midcol_reset_outputs", 80'({m_valid, m_last, s_ready, m_data}), 80'({1'b0, 1'b0, 1'b1, 64'h0}));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("after_midcol_reset", 80'({m_valid, s_ready}), 80'({1'b0, 1'b1}));
    @(posedge clk);
    #1;
    rand_block(c);
    expect_block(c);
    rx_cnt = 0;
    send_block(c, t);
    s_valid = 1'b0;
    drain();
    check("post_reset_rows", 80'(rx_cnt), 80'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
